// File: rtl/gauss_window_ctrl.sv
// 5x5 window sequencer for the Gaussian blur stage: four line buffers plus a
// shifting window register, raster-order ready/valid in, one window per interior pixel out.
module gauss_window_ctrl #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sof,
  input  logic [7:0]                    in_pix,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [199:0]                  win,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_y,
  output logic                          frame_done,
  output logic                          busy
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

  state_t              state;
  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic [7:0]          lb0 [IMG_WIDTH];
  logic [7:0]          lb1 [IMG_WIDTH];
  logic [7:0]          lb2 [IMG_WIDTH];
  logic [7:0]          lb3 [IMG_WIDTH];
  logic [4:0][4:0][7:0] wr;     // [row][col][bit]; row 0 = oldest line, col 0 = oldest column
  logic [4:0][7:0]     col;     // incoming column, index 0 = top
  logic                accept;
  logic                transfer;
  logic                eol;
  logic                last_pix;
  logic                emit;

  assign in_ready = ((state == FILL) || (state == STREAM)) && (!out_valid || out_ready);
  // A restart pulse wins over a pixel offered in the same cycle.
  assign accept   = in_valid && in_ready && !sof;
  assign transfer = out_valid && out_ready;
  assign eol      = (x == XW'(IMG_WIDTH - 1));
  assign last_pix = eol && (y == YW'(IMG_HEIGHT - 1));
  assign emit     = (x >= XW'(4)) && (y >= YW'(4));
  assign win      = wr;
  assign busy     = (state != IDLE);

  always_comb begin
    col = {in_pix, lb0[x], lb1[x], lb2[x], lb3[x]};
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb3[x] <= lb2[x];
      lb2[x] <= lb1[x];
      lb1[x] <= lb0[x];
      lb0[x] <= in_pix;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      wr         <= '0;
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (accept) begin
        for (int unsigned r = 0; r < 5; r++) begin
          wr[r] <= {col[r], wr[r][4:1]};
        end
        if (eol) begin
          x <= '0;
          y <= last_pix ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
        out_valid <= emit;
        if (emit) begin
          out_x <= x - XW'(2);
          out_y <= y - YW'(2);
        end
      end else if (transfer) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: ;
        FILL: begin
          if (accept && last_pix)  state <= DRAIN;
          else if (accept && emit) state <= STREAM;
        end
        STREAM: begin
          if (accept && last_pix) state <= DRAIN;
        end
        DRAIN: begin
          if (transfer) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (sof) begin
        state     <= FILL;
        x         <= '0;
        y         <= '0;
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gauss_window_ctrl.sv
// Scoreboard bench for gauss_window_ctrl on an 8x6 frame: expected windows are
// built from a bench-side image model at accept time and compared on transfer.
module tb_gauss_window_ctrl;
  localparam int W = 8;
  localparam int H = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         sof;
  logic [7:0]   in_pix;
  logic         in_valid;
  logic         in_ready;
  logic         out_ready;
  logic         out_valid;
  logic [199:0] win;
  logic [2:0]   out_x;
  logic [2:0]   out_y;
  logic         frame_done;
  logic         busy;

  always #5 clk = ~clk;

  gauss_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .sof        (sof),
    .in_pix     (in_pix),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .win        (win),
    .out_x      (out_x),
    .out_y      (out_y),
    .frame_done (frame_done),
    .busy       (busy)
  );

  typedef struct packed {
    logic [2:0]   x;
    logic [2:0]   y;
    logic [199:0] w;
  } exp_t;

  exp_t       q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_win   = 0;
  int         n_fd    = 0;
  int         cur_pat = 0;
  logic       prev_xfer = 1'b0;
  logic [7:0] img [H][W];

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pixval(input int pat, input int px, input int py);
    case (pat)
      0:       return 8'(8 * py + px);
      1:       return 8'd100;
      default: return 8'(200 - 3 * px - py);
    endcase
  endfunction

  function automatic int gauss(input logic [199:0] w);
    int k[5] = '{1, 4, 6, 4, 1};
    int s = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        s += k[r] * k[c] * int'(w[8 * (5 * r + c) +: 8]);
    return (s + 128) / 256;
  endfunction

  // Monitor: transfers pop the scoreboard; frame_done must follow the final transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (frame_done) begin
        n_fd++;
        check("fd_timing", {prev_xfer, (q.size() == 0)}, 2'b11);
      end
      prev_xfer = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_win", out_valid, 1'b0);
        end else begin
          e = q.pop_front();
          check("out_x", out_x, e.x);
          check("out_y", out_y, e.y);
          check("win", win, e.w);
          check("gauss", gauss(win), gauss(e.w));
          if (cur_pat == 1) check("gauss100", gauss(win), 100);
        end
        n_win++;
        prev_xfer = 1'b1;
      end
    end
  end

  task automatic run_frame(input int pat, input int vmode, input bit bp,
                           input int n_acc, input bit sof_with_valid);
    int   bx = 0, by = 0, acc = 0, cyc = 0, bp_cnt = 0;
    int   win_base = n_win;
    int   fd_base  = n_fd;
    exp_t e;
    cur_pat = pat;
    @(posedge clk); #1;
    sof = 1'b1; in_valid = sof_with_valid; in_pix = pixval(pat, 0, 0); out_ready = 1'b1;
    @(negedge clk);
    if (sof_with_valid) check("idle_sof_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    sof = 1'b0;
    check("busy_after_sof", busy, 1'b1);
    check("sof_clears_valid", out_valid, 1'b0);
    while (acc < n_acc && cyc < 500) begin
      in_valid = (vmode == 0) || (cyc % 2 == 0);
      in_pix   = pixval(pat, bx, by);
      if (bp && out_valid && n_win == win_base + 1 && bp_cnt < 3) begin
        out_ready = 1'b0;
        bp_cnt++;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (!out_ready) begin
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_x", out_x, 3'd3);
        check("bp_y", out_y, 3'd2);
        check("bp_k0", win[7:0], 8'd1);
        check("bp_k12", win[103:96], 8'd19);
      end
      if (in_valid && in_ready) begin
        img[by][bx] = in_pix;
        if (bx >= 4 && by >= 4) begin
          e.x = 3'(bx - 2);
          e.y = 3'(by - 2);
          for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
              e.w[8 * (5 * r + c) +: 8] = img[by - 4 + r][bx - 4 + c];
          q.push_back(e);
        end
        acc++;
        if (bx == W - 1) begin bx = 0; by++; end
        else bx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (acc < n_acc) check("accept_timeout", acc, n_acc);
    if (bp) check("bp_cycles", bp_cnt, 3);
    if (n_acc == W * H) begin
      for (int i = 0; i < 50 && n_fd == fd_base; i++) begin
        @(negedge clk); #1;
      end
      check("frame_done_cnt", n_fd - fd_base, 1);
      check("win_cnt", n_win - win_base, (W - 4) * (H - 4));
      check("q_empty", q.size(), 0);
      @(negedge clk); #1;
      check("fd_pulse", frame_done, 1'b0);
      check("busy_idle", busy, 1'b0);
    end
  endtask

  initial begin
    int base_w, base_fd;
    rst = 1'b1; sof = 1'b0; in_valid = 1'b0; in_pix = '0; out_ready = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_win", win, '0);
    check("rst_xy", {out_x, out_y}, '0);
    check("rst_fd_busy", {frame_done, busy}, '0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    run_frame(0, 0, 1'b0, W * H, 1'b1);   // ramp
    run_frame(1, 0, 1'b0, W * H, 1'b0);   // constant 100
    run_frame(0, 0, 1'b1, W * H, 1'b0);   // backpressure at 2nd window
    run_frame(0, 1, 1'b0, W * H, 1'b0);   // in_valid toggling

    base_w  = n_win;
    base_fd = n_fd;
    run_frame(2, 0, 1'b0, 5 * W + 4, 1'b0);   // abort after pixel (3,5)
    repeat (2) @(posedge clk);
    #1;
    check("abort_wins", n_win - base_w, 4);
    check("abort_q_empty", q.size(), 0);
    run_frame(0, 0, 1'b0, W * H, 1'b0);
    check("abort_fd_total", n_fd - base_fd, 1);

    run_frame(0, 0, 1'b0, 4 * W + 6, 1'b0);   // reset mid-STREAM
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_win", win, '0);
    check("mid_rst_xy", {out_x, out_y}, '0);
    check("mid_rst_fd_busy", {frame_done, busy}, '0);
    q.delete();
    @(posedge clk); #2 rst = 1'b0;
    base_w   = n_win;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_no_win", n_win - base_w, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
